// File: rtl/perf_pkg.sv
// rtl/perf_pkg.sv - shared types and constants for the perf counter-read bus
package perf_pkg;
  localparam int PERF_ADDR_W = 8;
  localparam int PERF_DATA_W = 32;
  localparam logic [PERF_DATA_W-1:0] PERF_TIMEOUT_DATA = 32'hffffffff;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT
  } perf_arb_state_t;
endpackage

// File: rtl/perf_if.sv
// rtl/perf_if.sv - perf counter-read bus (master drives addr/stb, slave returns stall/ack/data)
interface perf_if;
  import perf_pkg::*;
  logic [PERF_ADDR_W-1:0] addr;
  logic                   stb;
  logic                   stall;
  logic                   ack;
  logic [PERF_DATA_W-1:0] data;

  modport master (output addr, output stb, input stall, input ack, input data);
  modport slave  (input addr, input stb, output stall, output ack, output data);
endinterface

// File: rtl/perf_arbiter_rr_pick.sv
// rtl/perf_arbiter_rr_pick.sv - combinational round-robin picker: first set request at or after ptr
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          valid,
  output logic [IW-1:0] idx
);
  int j;

  // Scan from the far end so the last hit written is the nearest one to ptr.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    j     = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % N;
      if (req[j]) begin
        valid = 1'b1;
        idx   = IW'(j);
      end
    end
  end
endmodule

// File: rtl/perf_arbiter.sv
// rtl/perf_arbiter.sv - round-robin arbiter sharing one perf_if read bus; PERF_ARB_TIMEOUT_EN adds a transaction timeout
module perf_arbiter
  import perf_pkg::*;
#(
  parameter int N    = 2,
  parameter int TMOW = 8
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic [N-1:0]           req_stb,
  input  logic [N*8-1:0]         req_addr,
  output logic [N-1:0]           req_stall,
  output logic [N-1:0]           req_ack,
  output logic [PERF_DATA_W-1:0] req_data,
  output logic [15:0]            timeout_cnt,
  perf_if.master                 perf
);
  localparam int IW = $clog2(N);

  if (N < 2 || N > 8) begin : g_bad_n
    $error("perf_arbiter: N must be 2..8");
  end
  if (TMOW < 1 || TMOW > 16) begin : g_bad_tmow
    $error("perf_arbiter: TMOW must be 1..16");
  end

  perf_arb_state_t        state;
  logic [IW-1:0]          grant;
  logic [IW-1:0]          rr_ptr;
  logic [IW-1:0]          next_ptr;
  logic [IW-1:0]          pick_idx;
  logic                   pick_valid;
  logic                   stb_q;
  logic [PERF_ADDR_W-1:0] addr_q;

  rr_pick #(.N(N), .IW(IW)) u_pick (
    .req   (req_stb),
    .ptr   (rr_ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign perf.stb  = stb_q;
  assign perf.addr = addr_q;
  assign next_ptr  = (grant == IW'(N - 1)) ? '0 : grant + 1'b1;

  // Only the granted requester sees the live downstream stall.
  always_comb begin
    req_stall = '1;
    if (state == S_ISSUE) req_stall[grant] = perf.stall;
  end

`ifdef PERF_ARB_TIMEOUT_EN
  logic [TMOW-1:0] timer;
`else
  assign timeout_cnt = 16'h0000;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state    <= S_IDLE;
      grant    <= '0;
      rr_ptr   <= '0;
      stb_q    <= 1'b0;
      addr_q   <= '0;
      req_ack  <= '0;
      req_data <= '0;
`ifdef PERF_ARB_TIMEOUT_EN
      timer       <= '0;
      timeout_cnt <= '0;
`endif
    end else begin
      req_ack <= '0;
      case (state)
        S_IDLE: begin
          if (pick_valid) begin
            grant  <= pick_idx;
            addr_q <= req_addr[int'(pick_idx)*8 +: 8];
            stb_q  <= 1'b1;
            state  <= S_ISSUE;
`ifdef PERF_ARB_TIMEOUT_EN
            timer  <= '0;
`endif
          end
        end
        S_ISSUE, S_WAIT: begin
`ifdef PERF_ARB_TIMEOUT_EN
          timer <= timer + 1'b1;
`endif
          // An ack completes the transaction from either state, even before stall drops.
          if (perf.ack) begin
            req_data       <= perf.data;
            req_ack[grant] <= 1'b1;
            rr_ptr         <= next_ptr;
            stb_q          <= 1'b0;
            addr_q         <= '0;
            state          <= S_IDLE;
`ifdef PERF_ARB_TIMEOUT_EN
          end else if (timer == '1) begin
            req_data       <= PERF_TIMEOUT_DATA;
            req_ack[grant] <= 1'b1;
            rr_ptr         <= next_ptr;
            stb_q          <= 1'b0;
            addr_q         <= '0;
            state          <= S_IDLE;
            if (timeout_cnt != 16'hffff) timeout_cnt <= timeout_cnt + 16'd1;
`endif
          end else if (state == S_ISSUE && !perf.stall) begin
            stb_q  <= 1'b0;
            addr_q <= '0;
            state  <= S_WAIT;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_perf_arbiter.sv
// tb/tb_perf_arbiter.sv - table-driven bench for perf_arbiter (N=3, TMOW=4)
module tb_perf_arbiter;
  import perf_pkg::*;

  localparam int N = 3;

  logic          clk;
  logic          rst;
  logic [N-1:0]  req_stb;
  logic [N*8-1:0] req_addr;
  logic [N-1:0]  req_stall;
  logic [N-1:0]  req_ack;
  logic [31:0]   req_data;
  logic [15:0]   timeout_cnt;

  perf_if pif ();

  perf_arbiter #(.N(N), .TMOW(4)) dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .req_stb     (req_stb),
    .req_addr    (req_addr),
    .req_stall   (req_stall),
    .req_ack     (req_ack),
    .req_data    (req_data),
    .timeout_cnt (timeout_cnt),
    .perf        (pif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          r;
    logic [7:0]  addr;
    int          stall_n;
    int          ack_dly;
    logic [31:0] data;
    logic [2:0]  exp_ack;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wait_stb(input string nm);
    int n;
    n = 0;
    while (pif.stb !== 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
    end
    check({nm, "_stb_rise"}, {31'd0, pif.stb}, 32'd1);
  endtask

  task automatic run_txn(input vec_t v);
    req_stb[v.r] = 1'b1;
    req_addr[v.r*8 +: 8] = v.addr;
    @(negedge clk);
    wait_stb("txn");
    check("txn_addr", {24'd0, pif.addr}, {24'd0, v.addr});
    check("txn_stall_hi", {29'd0, req_stall}, 32'h7);
    repeat (v.stall_n) @(negedge clk);
    pif.stall = 1'b0;
    if (v.ack_dly == 0) begin
      pif.ack  = 1'b1;
      pif.data = v.data;
    end
    #1;
    check("txn_stall_fwd", {29'd0, req_stall}, {29'd0, ~v.exp_ack});
    @(negedge clk);
    req_stb[v.r] = 1'b0;
    if (v.ack_dly > 0) begin
      check("txn_stb_drop", {31'd0, pif.stb}, 32'd0);
      check("txn_addr_clr", {24'd0, pif.addr}, 32'd0);
      repeat (v.ack_dly - 1) @(negedge clk);
      pif.ack  = 1'b1;
      pif.data = v.data;
      @(negedge clk);
    end
    pif.ack   = 1'b0;
    pif.data  = 32'h0;
    pif.stall = 1'b1;
    check("txn_ack", {29'd0, req_ack}, {29'd0, v.exp_ack});
    check("txn_data", req_data, v.exp_data);
    @(negedge clk);
    check("txn_ack_single", {29'd0, req_ack}, 32'd0);
    @(negedge clk);
    check("txn_data_hold", req_data, v.exp_data);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int expg;
    int n;
    vecs[0] = '{r: 0, addr: 8'h05, stall_n: 2, ack_dly: 3, data: 32'h0000_1234, exp_ack: 3'b001, exp_data: 32'h0000_1234};
    vecs[1] = '{r: 1, addr: 8'ha7, stall_n: 0, ack_dly: 0, data: 32'h0000_cafe, exp_ack: 3'b010, exp_data: 32'h0000_cafe};
    vecs[2] = '{r: 2, addr: 8'hff, stall_n: 1, ack_dly: 1, data: 32'hdead_beef, exp_ack: 3'b100, exp_data: 32'hdead_beef};
    vecs[3] = '{r: 0, addr: 8'h00, stall_n: 0, ack_dly: 2, data: 32'h0000_0000, exp_ack: 3'b001, exp_data: 32'h0000_0000};
    vecs[4] = '{r: 1, addr: 8'h3c, stall_n: 3, ack_dly: 0, data: 32'h8000_0001, exp_ack: 3'b010, exp_data: 32'h8000_0001};

    rst       = 1'b1;
    req_stb   = '0;
    req_addr  = '0;
    pif.stall = 1'b1;
    pif.ack   = 1'b0;
    pif.data  = 32'h0;
    repeat (3) @(negedge clk);
    check("rst_stb", {31'd0, pif.stb}, 32'd0);
    check("rst_addr", {24'd0, pif.addr}, 32'd0);
    check("rst_ack", {29'd0, req_ack}, 32'd0);
    check("rst_data", req_data, 32'd0);
    check("rst_tmo", {16'd0, timeout_cnt}, 32'd0);
    check("rst_stall", {29'd0, req_stall}, 32'h7);
    rst = 1'b0;

    // Fairness: all three requesting, zero stall, ack on the accept cycle.
    req_addr  = {8'h30, 8'h20, 8'h10};
    req_stb   = 3'b111;
    pif.stall = 1'b0;
    expg = 0;
    for (int t = 0; t < 9; t++) begin
      @(negedge clk);
      wait_stb("fair");
      check("fair_addr", {24'd0, pif.addr}, 32'h10 * (expg + 1));
      pif.ack  = 1'b1;
      pif.data = 32'h100 + t;
      @(negedge clk);
      if (t == 8) req_stb = '0;
      pif.ack = 1'b0;
      check("fair_grant", {29'd0, req_ack}, 32'd1 << expg);
      check("fair_data", req_data, 32'h100 + t);
      expg = (expg + 1) % 3;
    end
    pif.stall = 1'b1;
    repeat (2) @(negedge clk);
    check("fair_idle", {31'd0, pif.stb}, 32'd0);

    // Contention: requesters 0 and 1 together from rr_ptr=0.
    do_reset();
    req_addr  = {8'h00, 8'h22, 8'h11};
    req_stb   = 3'b011;
    pif.stall = 1'b0;
    @(negedge clk);
    wait_stb("cont0");
    check("cont0_addr", {24'd0, pif.addr}, 32'h11);
    check("cont0_stall", {29'd0, req_stall}, 32'h6);
    pif.ack  = 1'b1;
    pif.data = 32'haaaa;
    @(negedge clk);
    req_stb[0] = 1'b0;
    pif.ack    = 1'b0;
    check("cont0_ack", {29'd0, req_ack}, 32'h1);
    check("cont1_wait_stall", {29'd0, req_stall}, 32'h7);
    @(negedge clk);
    wait_stb("cont1");
    check("cont1_addr", {24'd0, pif.addr}, 32'h22);
    check("cont1_stall", {29'd0, req_stall}, 32'h5);
    pif.ack  = 1'b1;
    pif.data = 32'hbbbb;
    @(negedge clk);
    req_stb = '0;
    pif.ack = 1'b0;
    check("cont1_ack", {29'd0, req_ack}, 32'h2);
    check("cont1_data", req_data, 32'hbbbb);
    pif.stall = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) run_txn(vecs[i]);

`ifdef PERF_ARB_TIMEOUT_EN
    // Slave accepts but never acks; expect a 0xffffffff completion.
    req_addr[7:0] = 8'h44;
    req_stb[0]    = 1'b1;
    pif.stall     = 1'b0;
    @(negedge clk);
    wait_stb("tmo");
    @(negedge clk);
    req_stb[0] = 1'b0;
    n = 1;
    while (req_ack === 3'b000 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("tmo_ack", {29'd0, req_ack}, 32'h1);
    check("tmo_data", req_data, PERF_TIMEOUT_DATA);
    check("tmo_cnt", {16'd0, timeout_cnt}, 32'd1);
    check("tmo_latency_ok", {31'd0, (n >= 14 && n <= 18)}, 32'd1);
    pif.stall = 1'b1;
    @(negedge clk);
    run_txn(vecs[1]);
`endif

    // Reset while waiting for ack, then a stray ack.
    req_addr[15:8] = 8'h66;
    req_stb[1]     = 1'b1;
    pif.stall      = 1'b0;
    @(negedge clk);
    wait_stb("rstw");
    @(negedge clk);
    req_stb   = '0;
    pif.stall = 1'b1;
    rst       = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstw_stb", {31'd0, pif.stb}, 32'd0);
    check("rstw_addr", {24'd0, pif.addr}, 32'd0);
    check("rstw_ack", {29'd0, req_ack}, 32'd0);
    check("rstw_data", req_data, 32'd0);
    check("rstw_tmo", {16'd0, timeout_cnt}, 32'd0);
    check("rstw_stall", {29'd0, req_stall}, 32'h7);
    pif.ack  = 1'b1;
    pif.data = 32'hbeef;
    @(negedge clk);
    pif.ack = 1'b0;
    check("stray_ack0", {29'd0, req_ack}, 32'd0);
    @(negedge clk);
    check("stray_ack1", {29'd0, req_ack}, 32'd0);
    check("stray_data", req_data, 32'd0);
    check("stray_idle", {31'd0, pif.stb}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
